noc_sequencer: RTL



---
 rtl/noc_sequencer_pkg.sv | 33 +++
 rtl/noc_sequencer_if.sv | 33 +++
 rtl/noc_seq_counter.sv | 33 +++
 rtl/noc_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/noc_sequencer_pkg.sv
// Shared definitions for the NoC phase sequencer: broadcast op codes,
// controller state encodings and the default widths.
package noc_sequencer_pkg;

    localparam int ROUTER_BITS    = 4;
    localparam int MAX_CYCLE_BITS = 16;

    // Ops broadcast to routers and traffic generators.
    typedef enum logic [3:0] {
        OP_NOP          = 4'd0,
        OP_INIT         = 4'd1,
        OP_LOAD_RT      = 4'd2,
        OP_LOAD_STAGING = 4'd3,
        OP_PHASE0       = 4'd4,
        OP_PHASE1       = 4'd5,
        OP_FILL         = 4'd8,
        OP_DEQUEUE      = 4'd9
    } op_e;

    // Controller states; INIT_TRAFFIC=6 and FILL=7 keep their legacy codes.
    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_INIT         = 4'd1,
        S_LOAD_RT      = 4'd2,
        S_LOAD_STAGING = 4'd3,
        S_PHASE0       = 4'd4,
        S_PHASE1       = 4'd5,
        S_INIT_TRAFFIC = 4'd6,
        S_FILL         = 4'd7,
        S_DONE         = 4'd8
    } state_e;

endpackage

// File: rtl/noc_sequencer_if.sv
// Control bundle between the simulation-top glue (master) and the phase
// sequencer (slave): run configuration in, broadcast ops and indices out.
interface noc_sequencer_if #(
    parameter int ROUTER_BITS    = 4,
    parameter int MAX_CYCLE_BITS = 16
);
    import noc_sequencer_pkg::*;

    logic                      start;
    logic [ROUTER_BITS:0]      num_routers;
    logic [MAX_CYCLE_BITS-1:0] max_cycle;
    logic                      fill_valid;
    logic                      all_done;

    op_e                       router_op;
    op_e                       traffic_op;
    logic                      fill_ack;
    logic [ROUTER_BITS-1:0]    rt_dst;
    logic [MAX_CYCLE_BITS-1:0] in_cycle;
    logic                      busy;
    logic                      done;

    modport master (
        output start, num_routers, max_cycle, fill_valid, all_done,
        input  router_op, traffic_op, fill_ack, rt_dst, in_cycle, busy, done
    );

    modport slave (
        input  start, num_routers, max_cycle, fill_valid, all_done,
        output router_op, traffic_op, fill_ack, rt_dst, in_cycle, busy, done
    );

endinterface

// File: rtl/noc_seq_counter.sv
// Loadable up-counter with a look-ahead terminal compare: next_hit is high
// when the value after the next increment equals terminal. terminal is one
// bit wider than the count so a full-range terminal (e.g. 16 with a 4-bit
// count) is representable.
module noc_seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH:0]   terminal,
    output logic [WIDTH-1:0] count,
    output logic             next_hit
);

    // Count register: load has priority over increment, otherwise hold.
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign next_hit = (({1'b0, count} + (WIDTH+1)'(1)) == terminal);

endmodule

// File: rtl/noc_sequencer.sv
// Global phase controller for the NoC simulation top. Broadcasts one op per
// clock: traffic init, traffic fill, router init, routing-table load, then
// LoadStaging/Phase0/Phase1 loops until the cycle budget is spent.
// All outputs are registered from the next-state decode.
// Optional feature: define NOC_SEQ_EARLY_EXIT_EN to end the run on the
// first Phase1 in which all_done is high.
module noc_sequencer #(
    parameter int ROUTER_SIZE    = 16,
    parameter int ROUTER_BITS    = noc_sequencer_pkg::ROUTER_BITS,
    parameter int MAX_CYCLE_BITS = noc_sequencer_pkg::MAX_CYCLE_BITS
) (
    input  logic           clk,
    input  logic           reset,
    noc_sequencer_if.slave bus
);
    import noc_sequencer_pkg::*;

    localparam logic [ROUTER_BITS:0] ROUTER_LIMIT = (ROUTER_BITS+1)'(ROUTER_SIZE);

    state_e                    state, state_next;
    op_e                       router_op_q, router_op_next;
    op_e                       traffic_op_q, traffic_op_next;
    logic                      fill_ack_q, fill_ack_next;
    logic                      busy_q, busy_next;
    logic                      done_q, done_next;

    logic [ROUTER_BITS:0]      num_q;
    logic [MAX_CYCLE_BITS-1:0] max_q;
    logic [ROUTER_BITS:0]      num_clamped;

    logic                      latch_cfg;
    logic                      rt_load, rt_inc, rt_last;
    logic                      cyc_load, cyc_inc, cyc_last;
    logic [ROUTER_BITS-1:0]    rt_dst;
    logic [MAX_CYCLE_BITS-1:0] in_cycle;
    logic                      exit_now;

    // Never index past the instantiated router array.
    assign num_clamped = (bus.num_routers > ROUTER_LIMIT) ? ROUTER_LIMIT : bus.num_routers;

`ifdef NOC_SEQ_EARLY_EXIT_EN
    assign exit_now = cyc_last || bus.all_done;
`else
    logic unused_all_done;
    assign unused_all_done = bus.all_done;
    assign exit_now        = cyc_last;
`endif

    // Routing-table destination index, reloaded to 0 on entry to LOAD_RT.
    noc_seq_counter #(.WIDTH(ROUTER_BITS)) u_rt_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (rt_load),
        .inc        (rt_inc),
        .load_value ('0),
        .terminal   (num_q),
        .count      (rt_dst),
        .next_hit   (rt_last)
    );

    // Simulated network cycle, cleared on start, stepped once per Phase1.
    noc_seq_counter #(.WIDTH(MAX_CYCLE_BITS)) u_cycle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cyc_load),
        .inc        (cyc_inc),
        .load_value ('0),
        .terminal   ({1'b0, max_q}),
        .count      (in_cycle),
        .next_hit   (cyc_last)
    );

    // Next-state decode plus registered-output values for the next state.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        router_op_next  = OP_NOP;
        traffic_op_next = OP_NOP;
        fill_ack_next   = 1'b0;
        latch_cfg       = 1'b0;
        rt_load         = 1'b0;
        rt_inc          = 1'b0;
        cyc_load        = 1'b0;
        cyc_inc         = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_next = S_INIT_TRAFFIC;
                    latch_cfg  = 1'b1;
                    cyc_load   = 1'b1;
                end
            end
            S_INIT_TRAFFIC: begin
                state_next    = S_FILL;
                fill_ack_next = bus.fill_valid;
            end
            S_FILL: begin
                // A registered NOP (no ack) marks the closing fill cycle.
                if (fill_ack_q) begin
                    fill_ack_next = bus.fill_valid;
                end else begin
                    state_next = S_INIT;
                end
            end
            S_INIT: begin
                if (num_q != '0) begin
                    state_next = S_LOAD_RT;
                    rt_load    = 1'b1;
                end else if (max_q == '0) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_LOAD_STAGING;
                end
            end
            S_LOAD_RT: begin
                if (rt_last) begin
                    state_next = (max_q == '0) ? S_DONE : S_LOAD_STAGING;
                end else begin
                    rt_inc = 1'b1;
                end
            end
            S_LOAD_STAGING: state_next = S_PHASE0;
            S_PHASE0:       state_next = S_PHASE1;
            S_PHASE1: begin
                cyc_inc    = 1'b1;
                state_next = exit_now ? S_DONE : S_LOAD_STAGING;
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_INIT_TRAFFIC: traffic_op_next = OP_INIT;
            S_FILL:         traffic_op_next = fill_ack_next ? OP_FILL : OP_NOP;
            S_INIT:         router_op_next  = OP_INIT;
            S_LOAD_RT:      router_op_next  = OP_LOAD_RT;
            S_LOAD_STAGING: router_op_next  = OP_LOAD_STAGING;
            S_PHASE0:       router_op_next  = OP_PHASE0;
            S_PHASE1:       router_op_next  = OP_PHASE1;
            default:        router_op_next  = OP_NOP;
        endcase

        busy_next = !(state_next inside {S_IDLE, S_DONE});
        done_next = (state_next == S_DONE);
    end

    // State and registered broadcast outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            router_op_q  <= OP_NOP;
            traffic_op_q <= OP_NOP;
            fill_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_next;
            router_op_q  <= router_op_next;
            traffic_op_q <= traffic_op_next;
            fill_ack_q   <= fill_ack_next;
            busy_q       <= busy_next;
            done_q       <= done_next;
        end
    end

    // Run configuration, captured only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_q <= '0;
            max_q <= '0;
        end else if (latch_cfg) begin
            num_q <= num_clamped;
            max_q <= bus.max_cycle;
        end
    end

    assign bus.router_op  = router_op_q;
    assign bus.traffic_op = traffic_op_q;
    assign bus.fill_ack   = fill_ack_q;
    assign bus.rt_dst     = rt_dst;
    assign bus.in_cycle   = in_cycle;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
